// File: rtl/prbs_error_checker.sv
// prbs_error_checker
// Receive-side PRBS7 (x^7+x^6+1) checker. Self-synchronises a local
// predictor to the incoming word stream, reports per-word bit errors once
// locked, and keeps saturating bit / bit-error / lock-loss counters for BER.
//
// Handshake: din is consumed on every rising edge where din_valid is high;
// there is no back-pressure, so a word offered with din_valid=1 is always
// taken that cycle. err_valid is a one-cycle pulse, registered one cycle
// after the word it describes, and err_bits is only meaningful while it is high.
module prbs_error_checker #(
   parameter int WIDTH    = 13,
   parameter int CNT_W    = 32,
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_valid,
   output logic [3:0]       err_bits,
   output logic [CNT_W-1:0] bits_cnt,
   output logic [CNT_W-1:0] bit_err_cnt,
   output logic [7:0]       lock_loss_cnt
);

   // Counter widths large enough to hold the thresholds themselves.
   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam int LC_W = $clog2(LOSS_CNT + 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [6:0]      s_q, s_d;          // predictor, s_q[0] is the newest bit
   logic [MC_W-1:0] match_q, match_d;  // consecutive clean words in VERIFY
   logic [LC_W-1:0] loss_q, loss_d;    // consecutive errored words in LOCKED

   logic [WIDTH-1:0] exp_word;         // word predicted from s_q
   logic [6:0]       exp_next;         // predictor state after exp_word
   logic [6:0]       gen;              // serial generator scratch
   logic [WIDTH-1:0] err_vec;
   logic [3:0]       pop;              // popcount of err_vec (WIDTH <= 15)
   logic             word_match;
   logic             check;            // a word is checked while LOCKED
   logic             lock_drop;        // LOCKED -> SEARCH this cycle

   // Saturating add: clamps at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   // Expected word: run the serial rule b[n] = b[n-7] ^ b[n-6] WIDTH times,
   // the first generated bit landing in the oldest (MSB) position.
   always_comb begin
      gen      = s_q;
      exp_word = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         exp_word[i] = gen[6] ^ gen[5];
         gen         = {gen[5:0], exp_word[i]};
      end
   end

   // Next predictor state is the newest seven bits of the expected word.
   assign exp_next   = exp_word[6:0];
   assign err_vec    = din ^ exp_word;
   assign word_match = (err_vec == '0);

   // Count differing bits between din and the prediction.
   always_comb begin
      pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + 4'(err_vec[i]);
      end
   end

   // Lock FSM state register together with predictor and run-length counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEARCH;
         s_q     <= '0;
         match_q <= '0;
         loss_q  <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         match_q <= match_d;
         loss_q  <= loss_d;
      end
   end

   // Lock FSM next state: acquire on a nonzero seed, confirm with LOCK_CNT
   // clean words, drop after LOSS_CNT consecutive errored words.
   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      match_d   = match_q;
      loss_d    = loss_q;
      check     = 1'b0;
      lock_drop = 1'b0;
      if (din_valid) begin
         case (state_q)
            SEARCH: begin
               // An all-zero seed would lock the generator up forever.
               if (din[6:0] != 7'd0) begin
                  s_d     = din[6:0];
                  match_d = '0;
                  state_d = VERIFY;
               end
            end
            VERIFY: begin
               if (word_match) begin
                  s_d = exp_next;
                  if (match_q == MC_W'(LOCK_CNT - 1)) begin
                     match_d = '0;
                     loss_d  = '0;
                     state_d = LOCKED;
                  end else begin
                     match_d = match_q + MC_W'(1);
                  end
               end else begin
                  // The bad word is not trusted as a new seed.
                  match_d = '0;
                  state_d = SEARCH;
               end
            end
            LOCKED: begin
               check = 1'b1;
               // Advance from the prediction so line errors never reach s.
               s_d   = exp_next;
               if (!word_match) begin
                  if (loss_q == LC_W'(LOSS_CNT - 1)) begin
                     loss_d    = '0;
                     lock_drop = 1'b1;
                     state_d   = SEARCH;
                  end else begin
                     loss_d = loss_q + LC_W'(1);
                  end
               end else begin
                  loss_d = '0;
               end
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end
   end

   // Registered per-word outputs and the lock indicator.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked    <= 1'b0;
         err_valid <= 1'b0;
         err_bits  <= '0;
      end else begin
         locked    <= (state_d == LOCKED);
         err_valid <= check;
         if (check) begin
            err_bits <= pop;
         end
      end
   end

   // Accumulated BER counters; clear wins over a same-cycle contribution.
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         bits_cnt      <= '0;
         bit_err_cnt   <= '0;
         lock_loss_cnt <= '0;
      end else begin
         if (check) begin
            bits_cnt    <= sat_add(bits_cnt, CNT_W'(WIDTH));
            bit_err_cnt <= sat_add(bit_err_cnt, CNT_W'(pop));
         end
         if (lock_drop && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_prbs_error_checker.sv
// Testbench for prbs_error_checker: a serial PRBS7 reference stream, table of
// per-word stimulus records with expected lock/err outputs, and a scoreboard
// queue of expected registered outputs including saturating counter models
// for a 32-bit and an 8-bit counter instance.
module tb_prbs_error_checker;
   localparam int W = 13;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst, din_valid, clr_cnt;
   logic [W-1:0] din;

   always #5 clk = ~clk;

   logic        locked, err_valid;
   logic [3:0]  err_bits;
   logic [31:0] bits_cnt, bit_err_cnt;
   logic [7:0]  lock_loss_cnt;

   logic        locked8, err_valid8;
   logic [3:0]  err_bits8;
   logic [7:0]  bits_cnt8, bit_err_cnt8;
   logic [7:0]  lock_loss_cnt8;

   prbs_error_checker #(.WIDTH(W), .CNT_W(32), .LOCK_CNT(4), .LOSS_CNT(4)) dut (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
      .locked(locked), .err_valid(err_valid), .err_bits(err_bits),
      .bits_cnt(bits_cnt), .bit_err_cnt(bit_err_cnt), .lock_loss_cnt(lock_loss_cnt)
   );

   prbs_error_checker #(.WIDTH(W), .CNT_W(8), .LOCK_CNT(4), .LOSS_CNT(4)) dut8 (
      .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_cnt(clr_cnt),
      .locked(locked8), .err_valid(err_valid8), .err_bits(err_bits8),
      .bits_cnt(bits_cnt8), .bit_err_cnt(bit_err_cnt8), .lock_loss_cnt(lock_loss_cnt8)
   );

   // ---------------- reference stream ----------------
   localparam int NBITS = 8192;
   logic sbits [0:NBITS-1];
   int   ptr = 0;

   // Word k is bits b[13k .. 13k+12], oldest bit in din[12].
   task automatic get_word(output logic [W-1:0] w);
      w = '0;
      for (int i = 0; i < W; i++) w[W-1-i] = sbits[ptr*W + i];
      ptr++;
   endtask

   // ---------------- stimulus table / scoreboard ----------------
   typedef struct {
      logic         rst;
      logic         v;
      logic         zero;
      logic         clr;
      logic [W-1:0] mask;
      logic         lk;
      logic         ev;
   } vec_t;

   typedef struct {
      logic       lk;
      logic       ev;
      logic       chk_eb;
      logic [3:0] eb;
      longint     bits, errs, loss;
      longint     bits8, errs8, loss8;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   int n_pass = 0;
   int n_total = 0;

   longint m_bits = 0, m_errs = 0, m_loss = 0;
   longint m_bits8 = 0, m_errs8 = 0, m_loss8 = 0;
   logic   m_prev_lk = 1'b0;

   function automatic longint sat(input longint a, input longint b, input int w);
      longint s, mx;
      s  = a + b;
      mx = (longint'(1) << w) - 1;
      return (s > mx) ? mx : s;
   endfunction

   task automatic chk(input string name, input longint act, input longint expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
   endtask

   task automatic add(input logic r, input logic v, input logic z, input logic c,
                      input logic [W-1:0] m, input logic lk, input logic ev);
      vec_t t;
      t.rst = r; t.v = v; t.zero = z; t.clr = c; t.mask = m; t.lk = lk; t.ev = ev;
      vecs.push_back(t);
   endtask

   // Drive one cycle, update the model, then compare after the edge.
   task automatic apply(input vec_t t);
      logic [W-1:0] w;
      exp_t e, got;
      logic [3:0] eb;
      @(negedge clk);
      rst       = t.rst;
      clr_cnt   = t.clr;
      din_valid = t.v && !t.rst;
      if (t.rst)       din = W'($urandom_range(0, 8191));
      else if (t.zero) din = '0;
      else if (t.v) begin
         get_word(w);
         din = w ^ t.mask;
      end else         din = W'($urandom_range(0, 8191));

      eb = t.ev ? 4'($countones(t.mask)) : 4'd0;
      if (t.rst || t.clr) begin
         m_bits = 0; m_errs = 0; m_loss = 0;
         m_bits8 = 0; m_errs8 = 0; m_loss8 = 0;
      end else begin
         if (t.ev) begin
            m_bits  = sat(m_bits, W, 32);
            m_errs  = sat(m_errs, longint'(eb), 32);
            m_bits8 = sat(m_bits8, W, 8);
            m_errs8 = sat(m_errs8, longint'(eb), 8);
         end
         if (m_prev_lk && !t.lk) begin
            m_loss  = sat(m_loss, 1, 8);
            m_loss8 = sat(m_loss8, 1, 8);
         end
      end
      m_prev_lk = t.rst ? 1'b0 : t.lk;

      e.lk = t.rst ? 1'b0 : t.lk;
      e.ev = t.rst ? 1'b0 : t.ev;
      e.chk_eb = t.rst || t.ev;
      e.eb = eb;
      e.bits = m_bits; e.errs = m_errs; e.loss = m_loss;
      e.bits8 = m_bits8; e.errs8 = m_errs8; e.loss8 = m_loss8;
      exp_q.push_back(e);

      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk("locked", locked, got.lk);
      chk("err_valid", err_valid, got.ev);
      if (got.chk_eb) chk("err_bits", err_bits, got.eb);
      chk("bits_cnt", bits_cnt, got.bits);
      chk("bit_err_cnt", bit_err_cnt, got.errs);
      chk("lock_loss_cnt", lock_loss_cnt, got.loss);
      chk("locked8", locked8, got.lk);
      chk("err_valid8", err_valid8, got.ev);
      if (got.chk_eb) chk("err_bits8", err_bits8, got.eb);
      chk("bits_cnt8", bits_cnt8, got.bits8);
      chk("bit_err_cnt8", bit_err_cnt8, got.errs8);
      chk("lock_loss_cnt8", lock_loss_cnt8, got.loss8);
   endtask

   task automatic run_table();
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
      vecs.delete();
   endtask

   // Five clean valid words from SEARCH: seed + four matching words.
   task automatic add_relock();
      for (int i = 0; i < 5; i++) add(0, 1, 0, 0, '0, (i == 4), 0);
   endtask

   // ---------------- test ----------------
   initial begin
      vec_t h;
      rst = 1'b1; din_valid = 1'b0; clr_cnt = 1'b0; din = '0;

      // Serial PRBS7: first word ends in seven ones (seed 7'h7F).
      for (int n = 0; n < 6; n++) sbits[n] = 1'b0;
      for (int n = 6; n < 13; n++) sbits[n] = 1'b1;
      for (int n = 13; n < NBITS; n++) sbits[n] = sbits[n-7] ^ sbits[n-6];

      // Reset state, clean lock, 100 locked clean words.
      add(1, 0, 0, 0, '0, 0, 0);
      add(1, 0, 0, 0, '0, 0, 0);
      add_relock();
      for (int i = 0; i < 100; i++) add(0, 1, 0, 0, '0, 1, 1);
      run_table();
      chk("clean_bits_1300", bits_cnt, 1300);
      chk("clean_errs_0", bit_err_cnt, 0);

      // Single-bit error, then clean words with idle gaps.
      add(0, 1, 0, 0, 13'h0001, 1, 1);
      for (int i = 0; i < 5; i++) add(0, 1, 0, 0, '0, 1, 1);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, '0, 1, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 0, 0, '0, 1, 1);
      run_table();
      chk("single_bit_errs", bit_err_cnt, 1);

      // Four fully inverted words: loss of lock on the fourth.
      for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 13'h1FFF, (i != 3), 1);
      run_table();
      chk("loss_errs_53", bit_err_cnt, 53);
      chk("loss_cnt_1", lock_loss_cnt, 1);
      chk("loss_unlocked", locked, 0);
      add_relock();
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, '0, 1, 1);
      // Three errored words then a clean one: loss run resets, lock kept.
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 13'h0101, 1, 1);
      for (int i = 0; i < 2; i++) add(0, 1, 0, 0, '0, 1, 1);
      run_table();

      // Clear colliding with an errored valid word.
      h.rst = 0; h.v = 1; h.zero = 0; h.clr = 1; h.mask = 13'h0003; h.lk = 1; h.ev = 1;
      apply(h);
      chk("clr_errs_0", bit_err_cnt, 0);
      h.clr = 0; h.mask = '0;
      apply(h);
      chk("after_clr_bits", bits_cnt, 13);

      // Saturation of the 8-bit counters: 3 errored + 1 clean, repeated.
      for (int g = 0; g < 8; g++) begin
         for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 13'h1FFF, 1, 1);
         add(0, 1, 0, 0, '0, 1, 1);
      end
      run_table();
      chk("sat_errs8_255", bit_err_cnt8, 255);
      chk("sat_bits8_255", bits_cnt8, 255);
      chk("sat_still_locked", locked, 1);

      // Reset mid-operation, then re-lock in five words.
      add(1, 0, 0, 0, '0, 0, 0);
      add_relock();
      for (int i = 0; i < 2; i++) add(0, 1, 0, 0, '0, 1, 1);
      // Zero words stay in SEARCH; seed + bad word returns from VERIFY.
      add(1, 0, 0, 0, '0, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 1, 1, 0, '0, 0, 0);
      add(0, 1, 0, 0, '0, 0, 0);
      add(0, 1, 0, 0, 13'h0040, 0, 0);
      add_relock();
      for (int i = 0; i < 2; i++) add(0, 0, 0, 0, '0, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, '0, 1, 1);
      run_table();
      chk("final_bits", bits_cnt, 39);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/prbs_error_checker.md
# prbs_error_checker

Receive-side checker of the IBERT datapath, directly downstream of the bit-error injection stage. It consumes 13-bit PRBS7 words that may contain errors. It self-synchronises a local PRBS7 generator to the stream, then compares each received word against the expected word. It reports per-word bit errors and keeps saturating bit and error counters for BER computation.

## Interface
- `WIDTH`, 13: data word width in bits. The generator and the popcount are sized from it.
- `CNT_W`, 32: width of the accumulated counters.
- `LOCK_CNT`, 4: consecutive error-free words required in VERIFY before entering LOCKED.
- `LOSS_CNT`, 4: consecutive errored words in LOCKED that force a return to SEARCH.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din_valid`  in  1  `din` holds a valid word this cycle.
- `din`  in  WIDTH  received word. `din[WIDTH-1]` is the oldest bit and `din[0]` the newest.
- `clr_cnt`  in  1  one-cycle pulse that zeroes the accumulated counters.
- `locked`  out  1  high while the state is LOCKED.
- `err_valid`  out  1  one-cycle pulse: a word was checked while LOCKED.
- `err_bits`  out  4  number of bit errors in the word reported by `err_valid`.
- `bits_cnt`  out  CNT_W  total bits checked while LOCKED; saturating.
- `bit_err_cnt`  out  CNT_W  total bit errors while LOCKED; saturating.
- `lock_loss_cnt`  out  8  number of LOCKED→SEARCH transitions; saturating at 255.

## Operation
- **PRBS7 definition:** polynomial x^7+x^6+1, serial sequence b[n] = b[n-7] ^ b[n-6].
- **Predictor state:** a 7-bit register `s` holds the last 7 bits, with `s[0]` the newest.
- **Expected word:** formed by iterating the serial rule WIDTH times, oldest bit first, so it is combinational from `s`. The next state is the 7 newest bits of that expected word.
- **Input gating:** no state, counter or output changes on cycles where `din_valid` is 0. The exceptions are `rst` and `clr_cnt`.
- **SEARCH:**
  - On a valid word with `din[6:0] != 0`, load `s <= din[6:0]`, clear the match counter and go to VERIFY.
  - A word with `din[6:0] == 0` is ignored, because the all-zero state is a PRBS lock-up state.
- **VERIFY:**
  - Compare `din` with the expected word.
  - On a match, advance `s` and increment the match counter. When the counter reaches LOCK_CNT, go to LOCKED.
  - On any mismatch, return to SEARCH. The mismatching word is not reused as a seed.
- **LOCKED:**
  - Compute the error vector as `din` XOR expected, and `err_bits` as its popcount.
  - Always advance `s` from the expected word, never from `din`, so input errors do not propagate into the predictor.
  - Pulse `err_valid`, add WIDTH to `bits_cnt`, and add `err_bits` to `bit_err_cnt`.
  - The loss counter counts consecutive words with `err_bits != 0` and clears on any clean word.
  - When the loss counter reaches LOSS_CNT, go to SEARCH and increment `lock_loss_cnt`. That final errored word is still counted.
- **Counter arithmetic:**
  - Additions saturate at 2^CNT_W-1 and never wrap.
  - `bits_cnt` and `bit_err_cnt` saturate independently.
- **Clear:** `clr_cnt` zeroes `bits_cnt`, `bit_err_cnt` and `lock_loss_cnt`. It does not affect the state, `s`, or the lock/loss counters.
- **Clear and valid in the same cycle:** clear has priority and that word's contribution is dropped. `err_valid` and `err_bits` are still produced for it.
- **Reset values:** all outputs are 0 and the state is SEARCH. `s`, the match counter and the loss counter are all 0.
  - Reset mid-stream discards all lock.
  - Re-lock takes 1 + LOCK_CNT valid words after the first usable word following reset deassertion.

## Timing
- **Output latency:** all outputs are registered, one cycle after the input word.
  - `err_valid` and `err_bits` for the word sampled at edge k appear after edge k.
  - `bits_cnt` and `bit_err_cnt` reflect that word after the same edge.
- **`locked`:** rises on the edge that accepts the LOCK_CNT-th matching VERIFY word. It falls on the edge that accepts the LOSS_CNT-th consecutive errored word.
- **Throughput:** one word per cycle at full rate; back-to-back `din_valid` is supported.
- **Idle cycles:** gaps in `din_valid` are transparent. The predictor advances only on valid words.

## Test plan
- **Clean lock:** clean PRBS7 stream, valid every cycle, seed `s=7'h7F`. Require `locked` high on edge 5 (1 seed word + 4 verify words), then no `err_valid` pulse with `err_bits != 0`. After 100 locked words, `bits_cnt` = 1300 and `bit_err_cnt` = 0.
- **Single-bit injection:** while locked, flip `din[0]` on one word. Require `err_bits` = 1 one cycle later, `bit_err_cnt` = 1, `locked` still high, and subsequent words clean (predictor not corrupted).
- **Multi-bit error and loss of lock:** while locked, XOR 4 consecutive words with 13'h1FFF. Require `err_bits` = 13 for each, `bit_err_cnt` += 52, `locked` low after the 4th, and `lock_loss_cnt` = 1. A resumed clean stream re-locks after 5 words.
- **Verify failure and zero seed:** all-zero words keep the block in SEARCH indefinitely. A seed word followed by an errored word returns it from VERIFY to SEARCH with no counter change.
- **Clear collision and saturation:**
  - With CNT_W=8, drive an errored stream until `bit_err_cnt` holds 255 and check it does not wrap.
  - Assert `clr_cnt` together with an errored valid word. Require `bit_err_cnt` = 0 while `err_valid` still pulses.
- **Reset mid-operation:** assert `rst` for 1 cycle while locked. Require all outputs 0 on the next edge, then re-lock after 5 valid words.
